// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic EX/MEM pipeline stage: state encoding,
// control bit positions and default field widths.
package pipe_pkg;

   // Default field widths, matching the fixed EX/MEM register this replaces.
   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned RN_W_DEF   = 5;
   localparam int unsigned CTRL_W_DEF = 3;

   // Bit positions inside the control vector.
   localparam int unsigned CTRL_WREG  = 0;
   localparam int unsigned CTRL_M2REG = 1;
   localparam int unsigned CTRL_WMEM  = 2;

   // Occupancy doubles as the state encoding; 2'd3 is never legal.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } pipe_state_e;

   // The stage can take a new entry next cycle unless both slots will be occupied.
   function automatic logic ready_after(input pipe_state_e s);
      return (s != ST_FULL);
   endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry {ctrl, alu, b, rn} with load enable. The control bits can be
// cleared on their own so a squashed entry becomes an inert bubble while the
// wide data fields are left untouched.
module pipe_entry_reg #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned RN_W   = 5,
   parameter int unsigned CTRL_W = 3
) (
   input  logic              clk,
   input  logic              clrn,
   input  logic              load,
   input  logic              clr_ctrl,
   input  logic [CTRL_W-1:0] d_ctrl,
   input  logic [DATA_W-1:0] d_alu,
   input  logic [DATA_W-1:0] d_b,
   input  logic [RN_W-1:0]   d_rn,
   output logic [CTRL_W-1:0] q_ctrl,
   output logic [DATA_W-1:0] q_alu,
   output logic [DATA_W-1:0] q_b,
   output logic [RN_W-1:0]   q_rn
);

   logic [CTRL_W-1:0] ctrl_q;
   logic [DATA_W-1:0] alu_q;
   logic [DATA_W-1:0] b_q;
   logic [RN_W-1:0]   rn_q;

   // Control bits: clear wins over load so a squash can never leave enables set.
   always_ff @(posedge clk or posedge clrn) begin
      if (clrn) begin
         ctrl_q <= '0;
      end else if (clr_ctrl) begin
         ctrl_q <= '0;
      end else if (load) begin
         ctrl_q <= d_ctrl;
      end
   end

   // Data fields: only the load enable matters; stale data is masked by ctrl.
   always_ff @(posedge clk or posedge clrn) begin
      if (clrn) begin
         alu_q <= '0;
         b_q   <= '0;
         rn_q  <= '0;
      end else if (load) begin
         alu_q <= d_alu;
         b_q   <= d_b;
         rn_q  <= d_rn;
      end
   end

   assign q_ctrl = ctrl_q;
   assign q_alu  = alu_q;
   assign q_b    = b_q;
   assign q_rn   = rn_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic EX/MEM stage: valid/ready handshake on both sides with a main and a
// skid entry so in_ready comes straight from a flop. The output always shows the
// main entry; the skid entry only catches the one beat that arrives while the
// downstream stalls, and refills main once the downstream drains it.
module pipe_skid_stage
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned RN_W   = RN_W_DEF,
   parameter int unsigned CTRL_W = CTRL_W_DEF
) (
   input  logic              clk,
   input  logic              clrn,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_alu,
   input  logic [DATA_W-1:0] in_b,
   input  logic [RN_W-1:0]   in_rn,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_alu,
   output logic [DATA_W-1:0] out_b,
   output logic [RN_W-1:0]   out_rn,
   output logic [1:0]        count
);

   pipe_state_e state_q, state_d;
   logic        in_ready_q;

   logic        in_fire;
   logic        out_fire;
   logic        main_load;
   logic        skid_load;
   logic        main_from_skid;

   logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_d_ctrl;
   logic [DATA_W-1:0] main_alu, skid_alu, main_d_alu;
   logic [DATA_W-1:0] main_b, skid_b, main_d_b;
   logic [RN_W-1:0]   main_rn, skid_rn, main_d_rn;

   assign in_fire  = in_valid & in_ready_q;
   assign out_fire = out_valid & out_ready;

   // Next-state and entry load decisions; flush overrides every transition.
   always_comb begin
      state_d        = state_q;
      main_load      = 1'b0;
      skid_load      = 1'b0;
      main_from_skid = 1'b0;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         unique case (state_q)
            ST_EMPTY: begin
               if (in_fire) begin
                  state_d   = ST_BUSY;
                  main_load = 1'b1;
               end
            end
            ST_BUSY: begin
               if (in_fire && out_fire) begin
                  main_load = 1'b1;
               end else if (in_fire) begin
                  state_d   = ST_FULL;
                  skid_load = 1'b1;
               end else if (out_fire) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               // in_ready is low here, so only the drain side can move.
               if (out_fire) begin
                  state_d        = ST_BUSY;
                  main_load      = 1'b1;
                  main_from_skid = 1'b1;
               end
            end
            default: begin
               state_d = ST_EMPTY;
            end
         endcase
      end
   end

   // State and registered ready; ready is derived from next state, never from out_ready.
   always_ff @(posedge clk or posedge clrn) begin
      if (clrn) begin
         state_q    <= ST_EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         in_ready_q <= ready_after(state_d);
      end
   end

   // Main refills from skid when draining out of FULL, otherwise from upstream.
   always_comb begin
      main_d_ctrl = in_ctrl;
      main_d_alu  = in_alu;
      main_d_b    = in_b;
      main_d_rn   = in_rn;
      if (main_from_skid) begin
         main_d_ctrl = skid_ctrl;
         main_d_alu  = skid_alu;
         main_d_b    = skid_b;
         main_d_rn   = skid_rn;
      end
   end

   pipe_entry_reg #(
      .DATA_W (DATA_W),
      .RN_W   (RN_W),
      .CTRL_W (CTRL_W)
   ) u_main (
      .clk      (clk),
      .clrn     (clrn),
      .load     (main_load),
      .clr_ctrl (flush),
      .d_ctrl   (main_d_ctrl),
      .d_alu    (main_d_alu),
      .d_b      (main_d_b),
      .d_rn     (main_d_rn),
      .q_ctrl   (main_ctrl),
      .q_alu    (main_alu),
      .q_b      (main_b),
      .q_rn     (main_rn)
   );

   pipe_entry_reg #(
      .DATA_W (DATA_W),
      .RN_W   (RN_W),
      .CTRL_W (CTRL_W)
   ) u_skid (
      .clk      (clk),
      .clrn     (clrn),
      .load     (skid_load),
      .clr_ctrl (flush),
      .d_ctrl   (in_ctrl),
      .d_alu    (in_alu),
      .d_b      (in_b),
      .d_rn     (in_rn),
      .q_ctrl   (skid_ctrl),
      .q_alu    (skid_alu),
      .q_b      (skid_b),
      .q_rn     (skid_rn)
   );

   // Outputs come from main; ctrl is masked so a bubble never enables a write.
   always_comb begin
      out_valid = (state_q != ST_EMPTY);
      out_ctrl  = '0;
      if (out_valid) begin
         out_ctrl = main_ctrl;
      end
      out_alu = main_alu;
      out_b   = main_b;
      out_rn  = main_rn;
   end

   assign in_ready = in_ready_q;
   assign count    = state_q;

   // Encoding 3 has no meaning; reaching it means the state flop was corrupted.
   assert property (@(posedge clk) disable iff (clrn) (2'(state_q) != 2'd3));

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed table plus corner sequences on the default-width stage, and a random
// valid/ready scoreboard run on a wide instance.
module tb_pipe_skid_stage;

   localparam logic [31:0] BMASK = 32'hFFFF_0000;

   logic clk = 1'b0;
   logic clrn;
   always #5 clk = ~clk;

   // Default-width instance.
   logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [2:0]  a_in_ctrl, a_out_ctrl;
   logic [31:0] a_in_alu, a_in_b, a_out_alu, a_out_b;
   logic [4:0]  a_in_rn, a_out_rn;
   logic [1:0]  a_count;

   // Wide instance.
   logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [4:0]  b_in_ctrl, b_out_ctrl;
   logic [63:0] b_in_alu, b_in_b, b_out_alu, b_out_b;
   logic [5:0]  b_in_rn, b_out_rn;
   logic [1:0]  b_count;

   pipe_skid_stage u_dut_a (
      .clk       (clk),
      .clrn      (clrn),
      .flush     (a_flush),
      .in_valid  (a_in_valid),
      .in_ready  (a_in_ready),
      .in_ctrl   (a_in_ctrl),
      .in_alu    (a_in_alu),
      .in_b      (a_in_b),
      .in_rn     (a_in_rn),
      .out_valid (a_out_valid),
      .out_ready (a_out_ready),
      .out_ctrl  (a_out_ctrl),
      .out_alu   (a_out_alu),
      .out_b     (a_out_b),
      .out_rn    (a_out_rn),
      .count     (a_count)
   );

   pipe_skid_stage #(
      .DATA_W (64),
      .RN_W   (6),
      .CTRL_W (5)
   ) u_dut_b (
      .clk       (clk),
      .clrn      (clrn),
      .flush     (b_flush),
      .in_valid  (b_in_valid),
      .in_ready  (b_in_ready),
      .in_ctrl   (b_in_ctrl),
      .in_alu    (b_in_alu),
      .in_b      (b_in_b),
      .in_rn     (b_in_rn),
      .out_valid (b_out_valid),
      .out_ready (b_out_ready),
      .out_ctrl  (b_out_ctrl),
      .out_alu   (b_out_alu),
      .out_b     (b_out_b),
      .out_rn    (b_out_rn),
      .count     (b_count)
   );

   typedef struct {
      logic        iv;
      logic        ordy;
      logic        fl;
      logic [2:0]  ctrl;
      logic [31:0] alu;
      logic [4:0]  rn;
      logic        ev;
      logic        er;
      logic [1:0]  ec;
      logic [2:0]  ectrl;
      logic [31:0] ealu;
      logic [4:0]  ern;
   } vec_t;

   typedef logic [138:0] b_entry_t;

   int checks   = 0;
   int failures = 0;

   logic [31:0] a_fired[$];
   b_entry_t    b_q[$];
   b_entry_t    b_prev;
   logic        b_prev_stall = 1'b0;
   int          b_in_n  = 0;
   int          b_out_n = 0;

   vec_t vecs[20];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input int iv, input int ordy, input int fl, input int ctrl,
                               input int alu, input int rn, input int ev, input int er,
                               input int ec, input int ectrl, input int ealu, input int ern);
      vec_t v;
      v.iv    = 1'(iv);
      v.ordy  = 1'(ordy);
      v.fl    = 1'(fl);
      v.ctrl  = 3'(ctrl);
      v.alu   = 32'(alu);
      v.rn    = 5'(rn);
      v.ev    = 1'(ev);
      v.er    = 1'(er);
      v.ec    = 2'(ec);
      v.ectrl = 3'(ectrl);
      v.ealu  = 32'(ealu);
      v.ern   = 5'(ern);
      return v;
   endfunction

   // Samples both instances just before the edge, then steps to 1 unit after it.
   task automatic cycle();
      b_entry_t cur;
      #7;
      if (a_out_valid && a_out_ready) a_fired.push_back(a_out_alu);
      cur = {b_out_ctrl, b_out_alu, b_out_b, b_out_rn};
      if (b_prev_stall) chk("b_stall_hold", 64'(cur != b_prev), 64'd0);
      if (b_out_valid && b_out_ready) begin
         b_out_n++;
         if (b_q.size() == 0) begin
            chk("b_spurious_out", 64'd1, 64'd0);
         end else begin
            b_entry_t e;
            e = b_q.pop_front();
            chk("b_order_ctrl", 64'(cur[138:134]), 64'(e[138:134]));
            chk("b_order_alu", cur[133:70], e[133:70]);
            chk("b_order_b", cur[69:6], e[69:6]);
            chk("b_order_rn", 64'(cur[5:0]), 64'(e[5:0]));
         end
      end
      if (b_in_valid && b_in_ready) begin
         b_in_n++;
         b_q.push_back({b_in_ctrl, b_in_alu, b_in_b, b_in_rn});
      end
      b_prev_stall = b_out_valid && !b_out_ready;
      b_prev       = cur;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_a_idle(input string tag);
      chk({tag, "_valid"}, 64'(a_out_valid), 64'd0);
      chk({tag, "_ctrl"}, 64'(a_out_ctrl), 64'd0);
      chk({tag, "_count"}, 64'(a_count), 64'd0);
      chk({tag, "_ready"}, 64'(a_in_ready), 64'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      //           iv or fl ctrl  alu   rn   ev er ec ectrl ealu  ern
      vecs[0]  = mk(1, 1, 0, 3'b001, 1, 1,   1, 1, 1, 3'b001, 1, 1);
      vecs[1]  = mk(1, 1, 0, 3'b010, 2, 2,   1, 1, 1, 3'b010, 2, 2);
      vecs[2]  = mk(1, 1, 0, 3'b100, 3, 3,   1, 1, 1, 3'b100, 3, 3);
      vecs[3]  = mk(1, 1, 0, 3'b011, 4, 4,   1, 1, 1, 3'b011, 4, 4);
      vecs[4]  = mk(0, 0, 0, 0, 0, 0,        1, 1, 1, 3'b011, 4, 4);
      vecs[5]  = mk(0, 1, 0, 0, 0, 0,        0, 1, 0, 0, 0, 0);
      vecs[6]  = mk(1, 0, 0, 3'b011, 'hA, 10, 1, 1, 1, 3'b011, 'hA, 10);
      vecs[7]  = mk(1, 0, 0, 3'b101, 'hB, 11, 1, 0, 2, 3'b011, 'hA, 10);
      vecs[8]  = mk(1, 0, 0, 3'b110, 'hC, 12, 1, 0, 2, 3'b011, 'hA, 10);
      vecs[9]  = mk(0, 1, 0, 0, 0, 0,        1, 1, 1, 3'b101, 'hB, 11);
      vecs[10] = mk(0, 1, 0, 0, 0, 0,        0, 1, 0, 0, 0, 0);
      vecs[11] = mk(1, 0, 0, 3'b111, 'h11, 1, 1, 1, 1, 3'b111, 'h11, 1);
      vecs[12] = mk(1, 0, 0, 3'b111, 'h12, 2, 1, 0, 2, 3'b111, 'h11, 1);
      vecs[13] = mk(1, 0, 1, 3'b111, 'h13, 3, 0, 1, 0, 0, 0, 0);
      vecs[14] = mk(1, 0, 0, 3'b001, 'h20, 3, 1, 1, 1, 3'b001, 'h20, 3);
      vecs[15] = mk(1, 0, 1, 3'b001, 'h21, 4, 0, 1, 0, 0, 0, 0);
      vecs[16] = mk(0, 1, 0, 0, 0, 0,        0, 1, 0, 0, 0, 0);
      vecs[17] = mk(1, 0, 0, 3'b001, 'h30, 7, 1, 1, 1, 3'b001, 'h30, 7);
      vecs[18] = mk(0, 1, 1, 0, 0, 0,        0, 1, 0, 0, 0, 0);
      vecs[19] = mk(0, 1, 0, 0, 0, 0,        0, 1, 0, 0, 0, 0);

      clrn        = 1'b1;
      a_flush     = 1'b0;
      a_in_valid  = 1'b0;
      a_out_ready = 1'b0;
      a_in_ctrl   = '0;
      a_in_alu    = '0;
      a_in_b      = '0;
      a_in_rn     = '0;
      b_flush     = 1'b0;
      b_in_valid  = 1'b0;
      b_out_ready = 1'b0;
      b_in_ctrl   = '0;
      b_in_alu    = '0;
      b_in_b      = '0;
      b_in_rn     = '0;

      #2;
      chk_a_idle("rst");
      chk("rst_alu", 64'(a_out_alu), 64'd0);
      chk("rst_rn", 64'(a_out_rn), 64'd0);
      @(posedge clk);
      #1;
      clrn = 1'b0;

      // Streaming, backpressure and flush corners from the table.
      for (int i = 0; i < 20; i++) begin
         a_in_valid  = vecs[i].iv;
         a_out_ready = vecs[i].ordy;
         a_flush     = vecs[i].fl;
         a_in_ctrl   = vecs[i].ctrl;
         a_in_alu    = vecs[i].alu;
         a_in_b      = vecs[i].alu ^ BMASK;
         a_in_rn     = vecs[i].rn;
         cycle();
         chk($sformatf("v%0d_valid", i), 64'(a_out_valid), 64'(vecs[i].ev));
         chk($sformatf("v%0d_ready", i), 64'(a_in_ready), 64'(vecs[i].er));
         chk($sformatf("v%0d_count", i), 64'(a_count), 64'(vecs[i].ec));
         chk($sformatf("v%0d_ctrl", i), 64'(a_out_ctrl), 64'(vecs[i].ectrl));
         if (vecs[i].ev) begin
            chk($sformatf("v%0d_alu", i), 64'(a_out_alu), 64'(vecs[i].ealu));
            chk($sformatf("v%0d_b", i), 64'(a_out_b), 64'(vecs[i].ealu ^ BMASK));
            chk($sformatf("v%0d_rn", i), 64'(a_out_rn), 64'(vecs[i].ern));
         end
      end
      a_flush = 1'b0;

      // Everything consumed downstream, in order, exactly once.
      chk("fired_n", 64'(a_fired.size()), 64'd7);
      if (a_fired.size() == 7) begin
         chk("fired_0", 64'(a_fired[0]), 64'h1);
         chk("fired_1", 64'(a_fired[1]), 64'h2);
         chk("fired_2", 64'(a_fired[2]), 64'h3);
         chk("fired_3", 64'(a_fired[3]), 64'h4);
         chk("fired_4", 64'(a_fired[4]), 64'hA);
         chk("fired_5", 64'(a_fired[5]), 64'hB);
         chk("fired_6", 64'(a_fired[6]), 64'h30);
      end

      // Asynchronous reset while full.
      a_in_valid  = 1'b1;
      a_out_ready = 1'b0;
      a_in_ctrl   = 3'b111;
      a_in_alu    = 32'h40;
      a_in_b      = 32'h40 ^ BMASK;
      a_in_rn     = 5'd9;
      cycle();
      a_in_alu = 32'h41;
      cycle();
      chk("prerst_count", 64'(a_count), 64'd2);
      a_in_valid = 1'b0;
      clrn       = 1'b1;
      #1;
      chk_a_idle("midrst");
      chk("midrst_alu", 64'(a_out_alu), 64'd0);
      chk("midrst_b", 64'(a_out_b), 64'd0);
      chk("midrst_rn", 64'(a_out_rn), 64'd0);
      @(posedge clk);
      #1;
      clrn = 1'b0;
      cycle();
      chk_a_idle("postrst");

      // Random valid/ready on the wide instance against the scoreboard.
      for (int n = 0; n < 10000; n++) begin
         b_in_valid  = 1'($urandom_range(0, 1));
         b_out_ready = 1'($urandom_range(0, 1));
         b_in_ctrl   = 5'($urandom());
         b_in_alu    = {$urandom(), $urandom()};
         b_in_b      = {$urandom(), $urandom()};
         b_in_rn     = 6'($urandom());
         cycle();
      end
      b_in_valid  = 1'b0;
      b_out_ready = 1'b1;
      repeat (4) cycle();
      chk("b_drained", 64'(b_q.size()), 64'd0);
      chk("b_in_out_match", 64'(b_out_n), 64'(b_in_n));
      chk("b_count_end", 64'(b_count), 64'd0);
      chk("b_valid_end", 64'(b_out_valid), 64'd0);
      chk("b_saw_traffic", 64'(b_in_n > 1000), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised successor to the fixed EX/MEM register.
- Carries control bits, ALU result, store data and destination register between two pipeline stages, using a valid/ready elastic handshake instead of free-running capture.
- A 2-entry buffer (main + skid) keeps in_ready a registered signal. This lets stages stall independently without combinational ready chains.
- Synchronous flush inserts bubbles for branch/exception squash.

Parameters:
- DATA_W, 32, width of alu and b data fields
- RN_W, 5, width of destination register number
- CTRL_W, 3, control bit vector width; bit0=wreg, bit1=m2reg, bit2=wmem

Ports:
- clk  in  1  clock, rising edge
- clrn  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous squash of all held entries
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage can accept an entry; registered
- in_ctrl  in  CTRL_W  control bits
- in_alu  in  DATA_W  ALU result
- in_b  in  DATA_W  store data
- in_rn  in  RN_W  destination register
- out_valid  out  1  downstream entry present
- out_ready  in  1  downstream accepts
- out_ctrl  out  CTRL_W  control bits; forced 0 when out_valid=0
- out_alu  out  DATA_W  ALU result
- out_b  out  DATA_W  store data
- out_rn  out  RN_W  destination register
- count  out  2  occupancy, 0..2

Behaviour:
- Reset: clk and clrn as already decided (clock clk; reset clrn, asynchronous, active-high). While clrn=1:
  - state=EMPTY, main and skid registers cleared to 0.
  - out_valid=0, out_ctrl=0, out_alu=0, out_b=0, out_rn=0, count=0.
  - in_ready=1.
- Handshake definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- State machine (registered):
  - EMPTY (count 0):
    - in_fire → BUSY, main<=in.
  - BUSY (count 1):
    - in_fire & out_fire → BUSY, main<=in.
    - in_fire & !out_fire → FULL, skid<=in.
    - !in_fire & out_fire → EMPTY.
    - otherwise hold.
  - FULL (count 2):
    - in_ready=0, so no in_fire is possible.
    - out_fire → BUSY, main<=skid.
    - otherwise hold.
- Registered ready: in_ready next = (next_state != FULL).
- Derived outputs: out_valid = (state != EMPTY); outputs are driven from main.
- Latency and throughput:
  - 1 cycle from in_fire in EMPTY to out_valid=1.
  - Sustained throughput 1 entry/cycle when out_ready=1.
- Ordering: strict FIFO; the skid entry never overtakes main.
- Stability: while out_valid=1 & out_ready=0, all out_* are held unchanged.
- Upstream obligation: upstream must not depend on in_ready combinationally. The stage never asserts in_ready combinationally from out_ready.
- Flush:
  - Next state EMPTY, count 0, in_ready 1, control bits of main and skid cleared.
  - Data fields may keep their stale values; out_ctrl=0 masks them.
  - An in_fire in the same cycle as flush is dropped.
  - An out_fire in the same cycle as flush still completes (downstream consumed it).
  - flush has priority over all transitions.
- Bubble semantics: out_ctrl=0 whenever out_valid=0, so downstream write/memory enables are inert. This matches legacy bubble behaviour.
- Reset mid-operation: asynchronous clear regardless of state; held entries are discarded.
- Widths: no arithmetic; fields pass through bit-exact. count is the 2-bit state encoding EMPTY=0, BUSY=1, FULL=2; 3 is unreachable and must trigger an assertion.

Decomposition:
- Shared package pipe_pkg:
  - state encoding constants ST_EMPTY, ST_BUSY, ST_FULL.
  - CTRL bit index constants CTRL_WREG, CTRL_M2REG, CTRL_WMEM.
  - Default widths DATA_W_DEF, RN_W_DEF.
- Natural sub-module: pipe_entry_reg. Holds one {ctrl, alu, b, rn} entry with load enable and ctrl-clear. Instantiated twice (main, skid).
- Control FSM stays in the top module.

Test Plan:
- Reset: assert clrn mid-stream with count=2 → same cycle all outputs 0, count=0; after release in_ready=1, out_valid=0.
- Streaming: in_valid=1 each cycle with alu=1,2,3,4, out_ready=1 → out_alu=1,2,3,4 on consecutive cycles, each 1 cycle after input; count stays 1.
- Backpressure:
  - out_ready=0, send alu=0xA then 0xB → count=2, in_ready=0 next cycle, out_alu=0xA held.
  - Raise out_ready → 0xA then 0xB emerge in order, in_ready returns 1 one cycle after the first out_fire.
- Flush while FULL: count=2, ctrl=3'b111 held, assert flush with in_valid=1 → next cycle out_valid=0, out_ctrl=0, count=0; the flushed-cycle input never appears at the output.
- Flush and out_fire in same cycle: BUSY with rn=7, out_ready=1, flush=1 → rn=7 consumed once, next state EMPTY, no duplicate.
- Parameter sweep: DATA_W=64, RN_W=6, CTRL_W=5 with random valid/ready (50%/50%, 10k cycles) → scoreboard shows output sequence equals input sequence, no loss, no duplicates, outputs stable under stall.
